// File: rtl/rom_pkg.sv
// Shared constants and state type for the program-ROM fetch path.
// Sized for the 4096 x 8 program ROM.
package rom_pkg;

   localparam int ROM_AW = 12;
   localparam int ROM_DW = 8;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      FETCH = 2'd1,
      HOLD  = 2'd2
   } fetch_state_t;

endpackage

// File: rtl/pc_counter.sv
// Program counter with load-over-increment priority.
// Also produces a registered one-cycle pulse when the count rolls over from all-ones.
module pc_counter
   import rom_pkg::*;
#(
   parameter int AW = ROM_AW
) (
   input  logic          clk_i,
   input  logic          rst_ni,
   input  logic          load_i,
   input  logic [AW-1:0] load_val_i,
   input  logic          inc_i,
   output logic [AW-1:0] pc_o,
   output logic          wrap_o
);

   logic [AW-1:0] pc_q, pc_d;
   logic          wrap_q, wrap_d;

   // A load cancels an increment in the same cycle, so it can never report a wrap.
   always_comb begin
      pc_d   = pc_q;
      wrap_d = 1'b0;
      if (load_i) begin
         pc_d = load_val_i;
      end else if (inc_i) begin
         pc_d   = pc_q + AW'(1);
         wrap_d = &pc_q;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         pc_q   <= '0;
         wrap_q <= 1'b0;
      end else begin
         pc_q   <= pc_d;
         wrap_q <= wrap_d;
      end
   end

   assign pc_o   = pc_q;
   assign wrap_o = wrap_q;

endmodule

// File: rtl/rom_fetch.sv
// Sequential program-ROM reader.
// Drives the ROM address from the PC and hands each byte downstream as instruction/operand nibbles over valid/ready.
module rom_fetch
   import rom_pkg::*;
#(
   parameter int AW = ROM_AW,
   parameter int DW = ROM_DW
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            start,
   input  logic            stop,
   input  logic            load,
   input  logic [AW-1:0]   load_addr,
   output logic [AW-1:0]   rom_addr,
   input  logic [DW-1:0]   rom_data,
   output logic [DW/2-1:0] instr,
   output logic [DW/2-1:0] oprnd,
   output logic            valid,
   input  logic            ready,
   output logic            busy,
   output logic            wrap
);

   fetch_state_t    state_q, state_d;
   logic            valid_q, valid_d;
   logic            stopPend_q, stopPend_d;
   logic [DW/2-1:0] instr_q, instr_d;
   logic [DW/2-1:0] oprnd_q, oprnd_d;
   logic            pcInc;

   pc_counter #(
      .AW(AW)
   ) u_pc (
      .clk_i      (clk),
      .rst_ni     (reset),
      .load_i     (load),
      .load_val_i (load_addr),
      .inc_i      (pcInc),
      .pc_o       (rom_addr),
      .wrap_o     (wrap)
   );

   // A stop arriving on the handshake cycle itself is honoured immediately.
   always_comb begin
      state_d    = state_q;
      valid_d    = valid_q;
      stopPend_d = stopPend_q;
      instr_d    = instr_q;
      oprnd_d    = oprnd_q;
      pcInc      = 1'b0;
      if (load) begin
         state_d    = IDLE;
         valid_d    = 1'b0;
         stopPend_d = 1'b0;
      end else begin
         unique case (state_q)
            IDLE: begin
               if (start) begin
                  state_d = FETCH;
               end
            end
            FETCH: begin
               state_d = HOLD;
               valid_d = 1'b1;
               instr_d = rom_data[DW-1:DW/2];
               oprnd_d = rom_data[DW/2-1:0];
               if (stop) begin
                  stopPend_d = 1'b1;
               end
            end
            HOLD: begin
               if (stop) begin
                  stopPend_d = 1'b1;
               end
               if (valid_q && ready) begin
                  pcInc   = 1'b1;
                  valid_d = 1'b0;
                  if (stopPend_q || stop) begin
                     state_d    = IDLE;
                     stopPend_d = 1'b0;
                  end else begin
                     state_d = FETCH;
                  end
               end
            end
            default: begin
               state_d = IDLE;
            end
         endcase
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q    <= IDLE;
         valid_q    <= 1'b0;
         stopPend_q <= 1'b0;
         instr_q    <= '0;
         oprnd_q    <= '0;
      end else begin
         state_q    <= state_d;
         valid_q    <= valid_d;
         stopPend_q <= stopPend_d;
         instr_q    <= instr_d;
         oprnd_q    <= oprnd_d;
      end
   end

   assign instr = instr_q;
   assign oprnd = oprnd_q;
   assign valid = valid_q;
   assign busy  = (state_q != IDLE);

endmodule

// File: tb/tb_rom_fetch.sv
// Bench for rom_fetch: directed walkthrough with literal expectations, then randomized traffic.
// A behavioural stream model is compared against the DUT on every falling edge.
module tb_rom_fetch;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        start = 1'b0;
   logic        stop = 1'b0;
   logic        load = 1'b0;
   logic [11:0] load_addr = '0;
   logic [11:0] rom_addr;
   logic [7:0]  rom_data;
   logic [3:0]  instr;
   logic [3:0]  oprnd;
   logic        valid;
   logic        ready = 1'b0;
   logic        busy;
   logic        wrap;

   int errCount = 0;
   int checkCount = 0;
   bit cmpEnable = 1'b0;

   rom_fetch dut (
      .clk       (clk),
      .reset     (reset),
      .start     (start),
      .stop      (stop),
      .load      (load),
      .load_addr (load_addr),
      .rom_addr  (rom_addr),
      .rom_data  (rom_data),
      .instr     (instr),
      .oprnd     (oprnd),
      .valid     (valid),
      .ready     (ready),
      .busy      (busy),
      .wrap      (wrap)
   );

   always #5 clk = ~clk;

   function automatic logic [7:0] romByte(input logic [11:0] a);
      return a[7:0] ^ 8'h5A;
   endfunction

   always_comb rom_data = romByte(rom_addr);

   // Stream model: 0 = idle, 1 = address presented, 2 = byte on offer.
   int          mPhase = 0;
   logic [11:0] mPc = '0;
   logic [7:0]  mByte = '0;
   logic        mStopSeen = 1'b0;
   logic        mWrap = 1'b0;

   always @(posedge clk or negedge reset) begin
      if (!reset) begin
         mPhase = 0;
         mPc = '0;
         mByte = '0;
         mStopSeen = 1'b0;
         mWrap = 1'b0;
      end else begin
         mWrap = 1'b0;
         if (load) begin
            mPc = load_addr;
            mPhase = 0;
            mStopSeen = 1'b0;
         end else if (mPhase == 0) begin
            if (start) mPhase = 1;
         end else if (mPhase == 1) begin
            mByte = romByte(mPc);
            mPhase = 2;
            if (stop) mStopSeen = 1'b1;
         end else begin
            if (stop) mStopSeen = 1'b1;
            if (ready) begin
               mWrap = (mPc == 12'hFFF);
               mPc = (mPc + 12'd1) % 13'd4096;
               if (mStopSeen) begin
                  mPhase = 0;
                  mStopSeen = 1'b0;
               end else begin
                  mPhase = 1;
               end
            end
         end
      end
   end

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      checkCount++;
      if (actual !== expected) begin
         errCount++;
         $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
      end
   endtask

   always @(negedge clk) begin
      if (cmpEnable) begin
         checkOutput("model_rom_addr", 32'(rom_addr), 32'(mPc));
         checkOutput("model_valid", 32'(valid), 32'(mPhase == 2));
         checkOutput("model_busy", 32'(busy), 32'(mPhase != 0));
         checkOutput("model_wrap", 32'(wrap), 32'(mWrap));
         if (mPhase == 2) begin
            checkOutput("model_instr", 32'(instr), 32'(mByte[7:4]));
            checkOutput("model_oprnd", 32'(oprnd), 32'(mByte[3:0]));
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic waitValid(input int budget);
      int n = 0;
      while (!valid && n < budget) begin
         @(negedge clk);
         n++;
      end
      if (!valid) begin
         errCount++;
         checkCount++;
         $display("[TB] FAIL valid_timeout: got valid=%0b, expected 1 within %0d cycles", valid, budget);
      end
   endtask

   task automatic checkByte(input string name, input logic [11:0] addr, input logic [3:0] ins, input logic [3:0] opr);
      checkOutput({name, "_addr"}, 32'(rom_addr), 32'(addr));
      checkOutput({name, "_instr"}, 32'(instr), 32'(ins));
      checkOutput({name, "_oprnd"}, 32'(oprnd), 32'(opr));
   endtask

   task automatic applyStimulus(input bit doStart, input bit doStop, input bit doLoad, input logic [11:0] addr, input bit rdy);
      start = doStart;
      stop = doStop;
      load = doLoad;
      load_addr = addr;
      ready = rdy;
   endtask

   initial begin
      #500000;
      $display("[TB] FAIL watchdog: got no finish, expected finish before 500000");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      logic [3:0] firstOprnd [3];
      firstOprnd[0] = 4'hA;
      firstOprnd[1] = 4'hB;
      firstOprnd[2] = 4'h8;

      #1 reset = 1'b0;
      #1 cmpEnable = 1'b1;
      #20;
      checkOutput("reset_addr", 32'(rom_addr), 32'h0);
      checkOutput("reset_valid", 32'(valid), 32'h0);
      checkOutput("reset_busy", 32'(busy), 32'h0);
      checkOutput("reset_wrap", 32'(wrap), 32'h0);
      checkOutput("reset_instr", 32'(instr), 32'h0);
      checkOutput("reset_oprnd", 32'(oprnd), 32'h0);
      #3 reset = 1'b1;

      // Stream from address 0 with ready held high.
      tick();
      applyStimulus(1, 0, 0, '0, 1);
      tick();
      start = 1'b0;
      for (int k = 0; k < 3; k++) begin
         waitValid(20);
         checkByte("stream", 12'(k), 4'h5, firstOprnd[k]);
         @(negedge clk);
      end

      // Backpressure at PC=3.
      tick();
      ready = 1'b0;
      waitValid(20);
      for (int k = 0; k < 5; k++) begin
         checkOutput("bp_valid", 32'(valid), 32'h1);
         checkByte("bp", 12'h003, 4'h5, 4'h9);
         @(negedge clk);
      end
      ready = 1'b1;
      tick();
      checkOutput("bp_release_addr", 32'(rom_addr), 32'h4);

      // Load near the top and stream through the wrap.
      applyStimulus(0, 0, 1, 12'hFFE, 1);
      tick();
      load = 1'b0;
      checkOutput("load_busy", 32'(busy), 32'h0);
      checkOutput("load_addr", 32'(rom_addr), 32'hFFE);
      start = 1'b1;
      tick();
      start = 1'b0;
      waitValid(20);
      checkByte("wrap_ffe", 12'hFFE, 4'hA, 4'h4);
      @(negedge clk);
      waitValid(20);
      checkByte("wrap_fff", 12'hFFF, 4'hA, 4'h5);
      tick();
      checkOutput("wrap_pulse", 32'(wrap), 32'h1);
      checkOutput("wrap_addr", 32'(rom_addr), 32'h0);
      tick();
      checkOutput("wrap_pulse_end", 32'(wrap), 32'h0);
      waitValid(20);
      checkByte("wrap_000", 12'h000, 4'h5, 4'hA);

      // Stop pulsed during FETCH at PC=7.
      applyStimulus(0, 0, 1, 12'h007, 1);
      tick();
      applyStimulus(1, 0, 0, '0, 1);
      tick();
      applyStimulus(0, 1, 0, '0, 1);
      tick();
      stop = 1'b0;
      waitValid(20);
      checkByte("stop_007", 12'h007, 4'h5, 4'hD);
      tick();
      checkOutput("stop_busy", 32'(busy), 32'h0);
      checkOutput("stop_addr", 32'(rom_addr), 32'h8);
      tick();
      checkOutput("stop_idle_busy", 32'(busy), 32'h0);

      // Load during HOLD with ready low; a simultaneous start is ignored.
      applyStimulus(1, 0, 0, '0, 0);
      tick();
      start = 1'b0;
      tick();
      checkOutput("hold_valid", 32'(valid), 32'h1);
      checkByte("hold_008", 12'h008, 4'h5, 4'h2);
      applyStimulus(1, 0, 1, 12'h010, 0);
      tick();
      applyStimulus(0, 0, 0, '0, 0);
      checkOutput("hold_load_valid", 32'(valid), 32'h0);
      checkOutput("hold_load_busy", 32'(busy), 32'h0);
      checkOutput("hold_load_addr", 32'(rom_addr), 32'h010);
      tick();
      checkOutput("hold_load_start_ignored", 32'(busy), 32'h0);

      // Reset asserted mid-HOLD takes effect without a clock edge.
      start = 1'b1;
      tick();
      start = 1'b0;
      tick();
      checkByte("rst_hold_010", 12'h010, 4'h4, 4'hA);
      #2 reset = 1'b0;
      #1;
      checkOutput("async_rst_valid", 32'(valid), 32'h0);
      checkOutput("async_rst_busy", 32'(busy), 32'h0);
      checkOutput("async_rst_addr", 32'(rom_addr), 32'h0);
      checkOutput("async_rst_instr", 32'(instr), 32'h0);
      checkOutput("async_rst_oprnd", 32'(oprnd), 32'h0);
      #10 reset = 1'b1;
      tick();
      applyStimulus(1, 0, 0, '0, 1);
      tick();
      start = 1'b0;
      waitValid(20);
      checkByte("post_rst_000", 12'h000, 4'h5, 4'hA);

      // Randomized traffic, checked by the model on every cycle.
      for (int c = 0; c < 3000; c++) begin
         tick();
         applyStimulus($urandom_range(0, 9) < 3,
                       $urandom_range(0, 19) == 0,
                       $urandom_range(0, 39) == 0,
                       ($urandom_range(0, 1) == 1) ? {8'hFF, 4'($urandom_range(0, 15))} : 12'($urandom),
                       $urandom_range(0, 9) < 6);
         if ($urandom_range(0, 299) == 0) begin
            #2 reset = 1'b0;
            @(posedge clk);
            #3 reset = 1'b1;
         end
      end

      tick();
      applyStimulus(0, 0, 0, '0, 1);
      repeat (4) tick();
      cmpEnable = 1'b0;
      $display("Result: errors=%0d of %0d checks", errCount, checkCount);
      $finish;
   end

endmodule
